bio_dma_arb: RTL

Round-robin arbiter and transfer sequencer that shares the single BIO DMA AHB master port among N requesters, such as the BIO cores' DMA channels.
It accepts one single-beat request at a time and runs a non-pipelined AHB SINGLE transfer (address phase, then data phase).
It returns the response to the owning requester.
Optional bus locking lets one requester perform atomic back-to-back transfers, bounded by a fairness limit.

---
 rtl/bio_dma_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bio_dma_arb.sv
// Round-robin arbiter sharing one AHB master port among N single-beat requesters,
// with optional bounded bus locking for atomic back-to-back transfers.
module bio_dma_arb #(
  parameter int N        = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic            aclk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N-1:0]    req_write,
  input  logic [N-1:0]    req_lock,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*3-1:0]  req_size,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic [1:0]      htrans,
  output logic            hwrite,
  output logic [AW-1:0]   haddr,
  output logic [2:0]      hsize,
  output logic [2:0]      hburst,
  output logic            hmasterlock,
  output logic [DW-1:0]   hwdata,
  input  logic [DW-1:0]   hrdata,
  input  logic            hready,
  input  logic            hresp
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
  localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t        state;
  logic [GW-1:0] rr, gnt_q, gnt_rr, gnt, idx;
  logic          hold, bypass, l_write, l_lock, misalign;
  logic [CW-1:0] cnt;
  logic [DW-1:0] l_wdata;
  logic [AW-1:0] sel_addr;
  logic [2:0]    sel_size;

  // Scan downward so the last hit is the first requester after rr.
  always_comb begin
    gnt_rr = '0;
    idx    = '0;
    for (int i = N; i >= 1; i--) begin
      idx = GW'((int'(rr) + i) % N);
      if (req_valid[idx]) gnt_rr = idx;
    end
  end

  assign bypass   = hold && req_valid[gnt_q];
  assign gnt      = bypass ? gnt_q : gnt_rr;
  assign sel_addr = req_addr[gnt*AW +: AW];
  assign sel_size = req_size[gnt*3 +: 3];
  assign misalign = (sel_size > 3'd2) ||
                    (sel_size == 3'd1 && sel_addr[0]) ||
                    (sel_size == 3'd2 && sel_addr[1:0] != 2'b00);

  assign req_ready = (state == IDLE && !reset && |req_valid) ? (ONE << gnt) : '0;
  assign rsp_valid = (state == ERR || (state == DATA && hready)) ? (ONE << gnt_q) : '0;
  assign rsp_err   = (state == ERR) || (state == DATA && hready && hresp);
  assign rsp_rdata = (state == DATA && hready && !l_write) ? hrdata : '0;
  assign hburst    = 3'b000;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= GW'(N - 1);
      gnt_q       <= '0;
      hold        <= 1'b0;
      cnt         <= '0;
      l_write     <= 1'b0;
      l_lock      <= 1'b0;
      l_wdata     <= '0;
      htrans      <= 2'b00;
      hwrite      <= 1'b0;
      haddr       <= '0;
      hsize       <= 3'b000;
      hmasterlock <= 1'b0;
      hwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hold && !req_valid[gnt_q]) begin
            hold        <= 1'b0;
            hmasterlock <= 1'b0;
            cnt         <= '0;
          end
          if (|req_valid) begin
            gnt_q   <= gnt;
            rr      <= gnt;
            l_write <= req_write[gnt];
            l_lock  <= req_lock[gnt];
            l_wdata <= req_wdata[gnt*DW +: DW];
            hold    <= 1'b0;
            if (misalign) begin
              state       <= ERR;
              hmasterlock <= 1'b0;
              cnt         <= '0;
            end else begin
              state       <= ADDR;
              htrans      <= 2'b10;
              haddr       <= sel_addr;
              hwrite      <= req_write[gnt];
              hsize       <= sel_size;
              hmasterlock <= req_lock[gnt];
              if (req_lock[gnt]) cnt <= (bypass ? cnt : '0) + 1'b1;
              else               cnt <= '0;
            end
          end
        end
        ADDR: begin
          if (hready) begin
            state  <= DATA;
            htrans <= 2'b00;
            haddr  <= '0;
            hwrite <= 1'b0;
            hsize  <= 3'b000;
            hwdata <= l_write ? l_wdata : '0;
          end
        end
        DATA: begin
          if (hready) begin
            state  <= IDLE;
            hwdata <= '0;
            // A clean locked completion keeps the bus for the owner until the limit.
            if (l_lock && !hresp && cnt < LMAX) begin
              hold <= 1'b1;
            end else begin
              hold        <= 1'b0;
              hmasterlock <= 1'b0;
              cnt         <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
